// File: rtl/byte_stream_arbiter.sv
// byte_stream_arbiter
// Shares one 8-bit string-detector input between two byte sources. A round-robin
// grant is held for a burst of up to MAX_BURST bytes or until the owner has been
// idle for IDLE_TIMEOUT cycles. Each change of owner passes through a FLUSH state
// that drives 0x00, so a pattern can never be assembled from bytes of two sources.
module byte_stream_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Req0_Valid,
    input  logic [7:0] Req0_Data,
    output logic       Req0_Ready,
    input  logic       Req1_Valid,
    input  logic [7:0] Req1_Data,
    output logic       Req1_Ready,
    output logic [7:0] Det_Data,
    output logic       Det_Valid,
    output logic [1:0] Grant,
    output logic       Busy
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_MAX_C  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST_C = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] IDLE_MAX_C   = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST_C  = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t          state_r;
    logic            ptr_r;          // 0: src0 wins a tie, 1: src1 wins a tie
    logic [BW-1:0]   burst_cnt_r;
    logic [IW-1:0]   idle_cnt_r;
    logic [7:0]      det_data_r;
    logic            det_valid_r;
    logic [1:0]      grant_r;

    logic            ready0_s;
    logic            ready1_s;
    logic            cur_valid_s;
    logic            cur_ready_s;
    logic [7:0]      cur_data_s;

    // Ready follows the owning state only; the burst limit closes it.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        case (state_r)
            GRANT0:  ready0_s = (burst_cnt_r < BURST_MAX_C);
            GRANT1:  ready1_s = (burst_cnt_r < BURST_MAX_C);
            default: begin
                ready0_s = 1'b0;
                ready1_s = 1'b0;
            end
        endcase
    end

    // Select the handshake signals of the current owner.
    always_comb begin
        cur_valid_s = 1'b0;
        cur_ready_s = 1'b0;
        cur_data_s  = 8'h00;
        if (state_r == GRANT1) begin
            cur_valid_s = Req1_Valid;
            cur_ready_s = ready1_s;
            cur_data_s  = Req1_Data;
        end else begin
            cur_valid_s = Req0_Valid;
            cur_ready_s = ready0_s;
            cur_data_s  = Req0_Data;
        end
    end

    // Arbitration FSM with registered detector and grant outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= 1'b0;
            burst_cnt_r <= '0;
            idle_cnt_r  <= '0;
            det_data_r  <= 8'h00;
            det_valid_r <= 1'b0;
            grant_r     <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    det_data_r  <= 8'h00;
                    det_valid_r <= 1'b0;
                    burst_cnt_r <= '0;
                    idle_cnt_r  <= '0;
                    if (Req0_Valid && (!Req1_Valid || !ptr_r)) begin
                        state_r <= GRANT0;
                        grant_r <= 2'b01;
                        ptr_r   <= 1'b1;
                    end else if (Req1_Valid) begin
                        state_r <= GRANT1;
                        grant_r <= 2'b10;
                        ptr_r   <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        grant_r <= 2'b00;
                    end
                end
                GRANT0, GRANT1: begin
                    if (cur_valid_s && cur_ready_s) begin
                        det_data_r  <= cur_data_s;
                        det_valid_r <= 1'b1;
                        idle_cnt_r  <= '0;
                        if (burst_cnt_r < BURST_MAX_C) begin
                            burst_cnt_r <= burst_cnt_r + BW'(1);
                        end else begin
                            burst_cnt_r <= burst_cnt_r;
                        end
                        if (burst_cnt_r == BURST_LAST_C) begin
                            state_r <= FLUSH;
                            grant_r <= 2'b00;
                        end else begin
                            state_r <= state_r;
                        end
                    end else begin
                        det_data_r  <= 8'h00;
                        det_valid_r <= 1'b0;
                        if (idle_cnt_r < IDLE_MAX_C) begin
                            idle_cnt_r <= idle_cnt_r + IW'(1);
                        end else begin
                            idle_cnt_r <= idle_cnt_r;
                        end
                        if (idle_cnt_r == IDLE_LAST_C) begin
                            state_r <= FLUSH;
                            grant_r <= 2'b00;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                FLUSH: begin
                    state_r     <= IDLE;
                    det_data_r  <= 8'h00;
                    det_valid_r <= 1'b0;
                    grant_r     <= 2'b00;
                    burst_cnt_r <= '0;
                    idle_cnt_r  <= '0;
                end
                default: begin
                    state_r     <= IDLE;
                    det_data_r  <= 8'h00;
                    det_valid_r <= 1'b0;
                    grant_r     <= 2'b00;
                    burst_cnt_r <= '0;
                    idle_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign Req0_Ready = ready0_s;
    assign Req1_Ready = ready1_s;
    assign Det_Data   = det_data_r;
    assign Det_Valid  = det_valid_r;
    assign Grant      = grant_r;
    assign Busy       = (state_r != IDLE);

endmodule
